serial_comparator: RTL and testbench



---
 rtl/comparator_pkg.sv | 17 +
 rtl/greater.sv | 10 +
 rtl/serial_comparator.sv | 147 ++++++++++++++
 tb/tb_serial_comparator.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package comparator_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Slice counter width; never narrower than one bit so WIDTH=2 still has a counter.
  function automatic int unsigned cnt_width(input int unsigned slices);
    int unsigned w;
    w = $clog2(slices);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/greater.sv
// 2-bit unsigned greater-than cell, purely combinational.
module greater (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       y
);

  assign y = (a > b);

endmodule

// File: rtl/serial_comparator.sv
// Multi-cycle magnitude comparator: walks operands MSB slice first through two
// 2-bit greater cells and holds a registered gt/eq/lt result on a valid/ready handshake.
module serial_comparator
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned SLICES = WIDTH / 2;
  localparam int unsigned CNT_W  = cnt_width(SLICES);

  if ((WIDTH == 0) || (WIDTH % 2 != 0)) begin : g_width_check
    $error("serial_comparator: WIDTH must be even and at least 2");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] sa_q, sb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             decided_q, gt_r_q;
  logic             out_valid_q, gt_q, eq_q, lt_q;

  logic             s_gt, s_lt;
  logic             decided_nx, gt_r_nx;
  logic             last_slice;

  greater u_greater_ab (
    .a (sa_q[WIDTH-1 -: 2]),
    .b (sb_q[WIDTH-1 -: 2]),
    .y (s_gt)
  );

  greater u_greater_ba (
    .a (sb_q[WIDTH-1 -: 2]),
    .b (sa_q[WIDTH-1 -: 2]),
    .y (s_lt)
  );

  assign last_slice = (cnt_q == '0);

  // First differing slice wins; later slices cannot overturn it.
  always_comb begin
    decided_nx = decided_q;
    gt_r_nx    = gt_r_q;
    if (!decided_q) begin
      if (s_gt) begin
        decided_nx = 1'b1;
        gt_r_nx    = 1'b1;
      end else if (s_lt) begin
        decided_nx = 1'b1;
        gt_r_nx    = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid)   state_d = StRun;
      StRun:   if (last_slice) state_d = StDone;
      StDone:  if (out_ready)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q        <= '0;
      sb_q        <= '0;
      cnt_q       <= '0;
      decided_q   <= 1'b0;
      gt_r_q      <= 1'b0;
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            sa_q      <= a;
            sb_q      <= b;
            decided_q <= 1'b0;
            gt_r_q    <= 1'b0;
            cnt_q     <= CNT_W'(SLICES - 1);
          end
        end
        StRun: begin
          sa_q      <= sa_q << 2;
          sb_q      <= sb_q << 2;
          decided_q <= decided_nx;
          gt_r_q    <= gt_r_nx;
          if (!last_slice) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            gt_q        <= decided_nx & gt_r_nx;
            lt_q        <= decided_nx & ~gt_r_nx;
            eq_q        <= ~decided_nx;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StIdle) & ~rst;
    out_valid = out_valid_q;
    gt        = gt_q;
    eq        = eq_q;
    lt        = lt_q;
  end

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench for serial_comparator: directed cases plus random operand pairs.
module tb_serial_comparator;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned SLICES = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic             gt, eq, lt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: ordinary unsigned comparison, encoded as {gt, eq, lt}.
  function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (x > y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input int hold);
    logic [2:0] exp;
    int lat;
    exp = ref_cmp(ta, tb);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", 32'(lat), 32'(SLICES));
    check("result", 32'({gt, eq, lt}), 32'(exp));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      @(posedge clk);
      #1;
      check("hold_result", 32'({out_valid, gt, eq, lt}), 32'({1'b1, exp}));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("cleared", 32'({out_valid, gt, eq, lt}), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 8'hFF;
    b         = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_outputs", 32'({out_valid, gt, eq, lt}), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    do_op(8'hA5, 8'h5A, 0);
    do_op(8'h3C, 8'h3C, 0);
    do_op(8'h00, 8'hFF, 0);
    do_op(8'h81, 8'h82, 0);
    do_op(8'h83, 8'h82, 0);
    do_op(8'h40, 8'h3F, 0);
    do_op(8'hC7, 8'h12, 5);

    // Reset during the second RUN cycle discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_outputs", 32'({out_valid, gt, eq, lt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_idle", 32'(in_ready), 32'd1);
    repeat (6) begin
      @(posedge clk);
      #1;
      check("rst_mid_no_valid", 32'(out_valid), 32'd0);
    end
    do_op(8'h10, 8'h10, 0);

    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      do_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
